conv2d_seq_mac: RTL and testbench

- Next-generation single-image 2D convolution engine that replaces the fixed 8-channel combinational MAC tree with one time-multiplexed MAC.
- Supports any channel count, reads weights and bias from external synchronous memories, and has a wide accumulator.
- Output is requantised: rounding right-shift, optional ReLU, saturation to DATA_WIDTH.
- Sits between the feature-map buffer and the next layer's buffer. It is driven by the layer sequencer through a start/busy/done handshake.

---
 rtl/conv2d_seq_mac.sv | 217 +++++++++++++++++++++
 tb/tb_conv2d_seq_mac.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_seq_mac.sv
// rtl/conv2d_seq_mac.sv - time-multiplexed single-MAC 2D convolution engine with requantised output
//
// Purpose: computes one output pixel at a time. Each pixel takes a bias fetch,
// one tap per cycle through IN_CHANNELS*K*K taps, one drain cycle and one write
// cycle. The accumulated value is requantised with a rounding arithmetic right
// shift, an optional ReLU and saturation to DATA_WIDTH.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 begin a layer (sampled only while idle)
//   shift, relu_en        requant controls, captured when start is accepted
//   busy, done            engine active / one-cycle completion pulse
//   in_addr/in_en/in_data input feature map read port (1-cycle latency)
//   w_addr/w_en/w_data    weight memory read port (1-cycle latency)
//   b_addr/b_en/b_data    bias memory read port (1-cycle latency)
//   out_addr/out_data/out_we  output feature map write port
module conv2d_seq_mac #(
   parameter int IN_CHANNELS  = 3,
   parameter int OUT_CHANNELS = 4,
   parameter int IN_HEIGHT    = 8,
   parameter int IN_WIDTH     = 8,
   parameter int KERNEL_SIZE  = 3,
   parameter int STRIDE       = 1,
   parameter int PADDING      = 1,
   parameter int DATA_WIDTH   = 8,
   parameter int ACC_WIDTH    = 24,
   parameter int ADDR_WIDTH   = 16,
   parameter int SHIFT_WIDTH  = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [SHIFT_WIDTH-1:0]       shift,
   input  logic                         relu_en,
   output logic                         busy,
   output logic                         done,
   output logic [ADDR_WIDTH-1:0]        in_addr,
   output logic                         in_en,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   output logic [ADDR_WIDTH-1:0]        w_addr,
   output logic                         w_en,
   input  logic signed [DATA_WIDTH-1:0] w_data,
   output logic [ADDR_WIDTH-1:0]        b_addr,
   output logic                         b_en,
   input  logic signed [ACC_WIDTH-1:0]  b_data,
   output logic [ADDR_WIDTH-1:0]        out_addr,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         out_we
);

   localparam int OH   = (IN_HEIGHT + 2*PADDING - KERNEL_SIZE) / STRIDE + 1;
   localparam int OW   = (IN_WIDTH  + 2*PADDING - KERNEL_SIZE) / STRIDE + 1;
   localparam int HW   = IN_HEIGHT * IN_WIDTH;
   localparam int KK   = KERNEL_SIZE * KERNEL_SIZE;
   localparam int TAPS = IN_CHANNELS * KK;
   localparam int OHW  = OH * OW;
   // Wide enough that the rounding constant for any shift value cannot overflow.
   localparam int EW   = ACC_WIDTH + 2**SHIFT_WIDTH;
   localparam logic signed [EW-1:0] SAT_MAX = EW'((2**(DATA_WIDTH-1)) - 1);
   localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_BIAS  = 3'd1;
   localparam logic [2:0] S_MAC   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]                  state_q, state_d;
   logic [31:0]                 oc_q, orow_q, ocol_q, ic_q, kr_q, kc_q;
   logic                        pad_q;
   logic [SHIFT_WIDTH-1:0]      shift_q;
   logic                        relu_q;
   logic signed [ACC_WIDTH-1:0] acc_q;
   logic [DATA_WIDTH-1:0]       out_data_q;
   logic [ADDR_WIDTH-1:0]       out_addr_q, in_addr_q, w_addr_q, b_addr_q;

   logic signed [31:0]              row_s, col_s;
   logic                            tap_inb, first_tap, last_tap, last_pix;
   logic signed [2*DATA_WIDTH-1:0]  mul;
   logic signed [ACC_WIDTH-1:0]     prod_ext, acc_sum;
   logic signed [EW-1:0]            acc_ext, rnd, v_sh, v_cl;
   logic [DATA_WIDTH-1:0]           q_val;

   // Tap geometry for the tap being issued this cycle.
   assign row_s     = $signed(orow_q*STRIDE + kr_q) - PADDING;
   assign col_s     = $signed(ocol_q*STRIDE + kc_q) - PADDING;
   assign tap_inb   = (row_s >= 0) && (row_s < IN_HEIGHT) && (col_s >= 0) && (col_s < IN_WIDTH);
   assign first_tap = (ic_q == 0) && (kr_q == 0) && (kc_q == 0);
   assign last_tap  = (ic_q == IN_CHANNELS-1) && (kr_q == KERNEL_SIZE-1) && (kc_q == KERNEL_SIZE-1);
   assign last_pix  = (oc_q == OUT_CHANNELS-1) && (orow_q == OH-1) && (ocol_q == OW-1);

   assign in_en = (state_q == S_MAC) && tap_inb;
   assign w_en  = (state_q == S_MAC);
   assign b_en  = (state_q == S_BIAS);

   // Addresses follow the live counters while enabled and otherwise hold.
   assign in_addr = in_en ? ADDR_WIDTH'(ic_q*HW + row_s*IN_WIDTH + col_s) : in_addr_q;
   assign w_addr  = w_en  ? ADDR_WIDTH'(oc_q*TAPS + ic_q*KK + kr_q*KERNEL_SIZE + kc_q) : w_addr_q;
   assign b_addr  = b_en  ? ADDR_WIDTH'(oc_q) : b_addr_q;

   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);
   assign out_we   = (state_q == S_WRITE);
   assign out_addr = out_addr_q;
   assign out_data = out_data_q;

   // The operands on in_data/w_data belong to the tap issued last cycle;
   // a padding tap contributes zero whatever stale value in_data holds.
   assign mul      = in_data * w_data;
   assign prod_ext = pad_q ? '0 : {{(ACC_WIDTH-2*DATA_WIDTH){mul[2*DATA_WIDTH-1]}}, mul};
   assign acc_sum  = acc_q + prod_ext;

   always_comb begin
      acc_ext = {{(EW-ACC_WIDTH){acc_sum[ACC_WIDTH-1]}}, acc_sum};
      rnd     = (shift_q != '0) ? (EW'(1) << (shift_q - 1'b1)) : '0;
      v_sh    = (acc_ext + rnd) >>> shift_q;
      v_cl    = v_sh;
      if (relu_q && (v_cl < 0)) begin
         v_cl = '0;
      end
      if (v_cl > SAT_MAX) begin
         v_cl = SAT_MAX;
      end else if (v_cl < SAT_MIN) begin
         v_cl = SAT_MIN;
      end
      q_val = DATA_WIDTH'(v_cl);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_BIAS;
         S_BIAS:  state_d = S_MAC;
         S_MAC:   if (last_tap) state_d = S_DRAIN;
         S_DRAIN: state_d = S_WRITE;
         S_WRITE: state_d = last_pix ? S_DONE : S_BIAS;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         oc_q       <= '0;
         orow_q     <= '0;
         ocol_q     <= '0;
         ic_q       <= '0;
         kr_q       <= '0;
         kc_q       <= '0;
         pad_q      <= 1'b0;
         shift_q    <= '0;
         relu_q     <= 1'b0;
         acc_q      <= '0;
         out_data_q <= '0;
         out_addr_q <= '0;
         in_addr_q  <= '0;
         w_addr_q   <= '0;
         b_addr_q   <= '0;
      end else begin
         state_q   <= state_d;
         in_addr_q <= in_addr;
         w_addr_q  <= w_addr;
         b_addr_q  <= b_addr;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  shift_q <= shift;
                  relu_q  <= relu_en;
                  oc_q    <= '0;
                  orow_q  <= '0;
                  ocol_q  <= '0;
                  ic_q    <= '0;
                  kr_q    <= '0;
                  kc_q    <= '0;
               end
            end
            S_MAC: begin
               pad_q <= !tap_inb;
               // Bias arrives during the first tap cycle and seeds the sum.
               acc_q <= first_tap ? b_data : acc_sum;
               if (kc_q == KERNEL_SIZE-1) begin
                  kc_q <= '0;
                  if (kr_q == KERNEL_SIZE-1) begin
                     kr_q <= '0;
                     ic_q <= (ic_q == IN_CHANNELS-1) ? '0 : ic_q + 1;
                  end else begin
                     kr_q <= kr_q + 1;
                  end
               end else begin
                  kc_q <= kc_q + 1;
               end
            end
            S_DRAIN: begin
               out_data_q <= q_val;
               out_addr_q <= ADDR_WIDTH'(oc_q*OHW + orow_q*OW + ocol_q);
            end
            S_WRITE: begin
               if (ocol_q == OW-1) begin
                  ocol_q <= '0;
                  if (orow_q == OH-1) begin
                     orow_q <= '0;
                     oc_q   <= (oc_q == OUT_CHANNELS-1) ? '0 : oc_q + 1;
                  end else begin
                     orow_q <= orow_q + 1;
                  end
               end else begin
                  ocol_q <= ocol_q + 1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_conv2d_seq_mac.sv
// tb/tb_conv2d_seq_mac.sv - self-checking bench for conv2d_seq_mac against a behavioural convolution model
module tb_conv2d_seq_mac;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Instance A: IC=1 OC=1 3x3 K=3 S=1 P=1.  Instance B: IC=3 OC=2 4x4 K=3 S=2 P=1.
   logic a_start = 1'b0, a_relu = 1'b0;
   logic [4:0] a_shift = '0;
   logic a_busy, a_done, a_in_en, a_w_en, a_b_en, a_out_we;
   logic [15:0] a_in_addr, a_w_addr, a_b_addr, a_out_addr;
   logic signed [7:0] a_in_data = '0, a_w_data = '0;
   logic [7:0] a_out_data;
   logic signed [23:0] a_b_data = '0;

   logic b_start = 1'b0, b_relu = 1'b0;
   logic [4:0] b_shift = '0;
   logic b_busy, b_done, b_in_en, b_w_en, b_b_en, b_out_we;
   logic [15:0] b_in_addr, b_w_addr, b_b_addr, b_out_addr;
   logic signed [7:0] b_in_data = '0, b_w_data = '0;
   logic [7:0] b_out_data;
   logic signed [23:0] b_b_data = '0;

   int a_in_mem[256], a_w_mem[256], a_b_mem[256];
   int b_in_mem[256], b_w_mem[256], b_b_mem[256];

   conv2d_seq_mac #(.IN_CHANNELS(1), .OUT_CHANNELS(1), .IN_HEIGHT(3), .IN_WIDTH(3),
      .KERNEL_SIZE(3), .STRIDE(1), .PADDING(1), .DATA_WIDTH(8), .ACC_WIDTH(24),
      .ADDR_WIDTH(16), .SHIFT_WIDTH(5)) dut_a (
      .clk(clk), .rst(rst), .start(a_start), .shift(a_shift), .relu_en(a_relu),
      .busy(a_busy), .done(a_done),
      .in_addr(a_in_addr), .in_en(a_in_en), .in_data(a_in_data),
      .w_addr(a_w_addr), .w_en(a_w_en), .w_data(a_w_data),
      .b_addr(a_b_addr), .b_en(a_b_en), .b_data(a_b_data),
      .out_addr(a_out_addr), .out_data(a_out_data), .out_we(a_out_we));

   conv2d_seq_mac #(.IN_CHANNELS(3), .OUT_CHANNELS(2), .IN_HEIGHT(4), .IN_WIDTH(4),
      .KERNEL_SIZE(3), .STRIDE(2), .PADDING(1), .DATA_WIDTH(8), .ACC_WIDTH(24),
      .ADDR_WIDTH(16), .SHIFT_WIDTH(5)) dut_b (
      .clk(clk), .rst(rst), .start(b_start), .shift(b_shift), .relu_en(b_relu),
      .busy(b_busy), .done(b_done),
      .in_addr(b_in_addr), .in_en(b_in_en), .in_data(b_in_data),
      .w_addr(b_w_addr), .w_en(b_w_en), .w_data(b_w_data),
      .b_addr(b_b_addr), .b_en(b_b_en), .b_data(b_b_data),
      .out_addr(b_out_addr), .out_data(b_out_data), .out_we(b_out_we));

   // Synchronous read memories, one cycle of latency.
   always @(posedge clk) begin
      if (a_in_en) a_in_data <= 8'(a_in_mem[a_in_addr[7:0]]);
      if (a_w_en)  a_w_data  <= 8'(a_w_mem[a_w_addr[7:0]]);
      if (a_b_en)  a_b_data  <= 24'(a_b_mem[a_b_addr[7:0]]);
      if (b_in_en) b_in_data <= 8'(b_in_mem[b_in_addr[7:0]]);
      if (b_w_en)  b_w_data  <= 8'(b_w_mem[b_w_addr[7:0]]);
      if (b_b_en)  b_b_data  <= 24'(b_b_mem[b_b_addr[7:0]]);
   end

   // Captured results of the most recent layer run.
   int  cap[256];
   bit  capv[256];
   int  n_wr, n_inen, done_cyc, gap_bad;
   bit  timed_out;
   logic post_busy, post_done;

   // Reference convolution for one output pixel, straight from the layer definition.
   function automatic int ref_pix(input int sel, input int oc, input int orow, input int ocol,
                                  input int shamt, input int relu);
      int icn, h, w, k, s, p, r, c, xin, wt;
      longint acc, v;
      if (sel == 0) begin icn = 1; h = 3; w = 3; k = 3; s = 1; p = 1; end
      else          begin icn = 3; h = 4; w = 4; k = 3; s = 2; p = 1; end
      acc = (sel == 0) ? longint'(a_b_mem[oc]) : longint'(b_b_mem[oc]);
      for (int ic = 0; ic < icn; ic++)
         for (int kr = 0; kr < k; kr++)
            for (int kc = 0; kc < k; kc++) begin
               r = orow*s + kr - p;
               c = ocol*s + kc - p;
               if (r >= 0 && r < h && c >= 0 && c < w) begin
                  xin = (sel == 0) ? a_in_mem[ic*h*w + r*w + c] : b_in_mem[ic*h*w + r*w + c];
                  wt  = (sel == 0) ? a_w_mem[oc*icn*k*k + ic*k*k + kr*k + kc]
                                   : b_w_mem[oc*icn*k*k + ic*k*k + kr*k + kc];
                  acc += longint'(xin) * longint'(wt);
               end
            end
      acc = acc & 64'hFFFFFF;
      if (acc >= 64'sh800000) acc -= 64'sh1000000;
      if (shamt > 0) acc += longint'(1) << (shamt - 1);
      v = acc >>> shamt;
      if (relu != 0 && v < 0) v = 0;
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      return int'(v);
   endfunction

   task automatic set_start(input int sel, input logic v);
      if (sel == 0) a_start = v; else b_start = v;
   endtask

   // Runs one layer. pulse_at: cycle to pulse start while busy (0 = never).
   // hold: keep start high until done. abort_at: cycle to apply reset (0 = never).
   task automatic run_layer(input int sel, input int shamt, input int relu,
                            input int hold, input int pulse_at, input int abort_at);
      logic we, ie, dn;
      logic [15:0] oa;
      logic [7:0] od;
      int last_wr, period;
      period = (sel == 0) ? 12 : 30;
      for (int i = 0; i < 256; i++) begin cap[i] = 0; capv[i] = 1'b0; end
      n_wr = 0; n_inen = 0; done_cyc = 0; gap_bad = 0; last_wr = -1; timed_out = 1'b0;
      @(negedge clk);
      if (sel == 0) begin a_shift = 5'(shamt); a_relu = 1'(relu); end
      else          begin b_shift = 5'(shamt); b_relu = 1'(relu); end
      set_start(sel, 1'b1);
      @(posedge clk);
      for (int cyc = 1; cyc <= 4000; cyc++) begin
         @(negedge clk);
         if (cyc == 1 && hold == 0) set_start(sel, 1'b0);
         if (cyc == pulse_at) set_start(sel, 1'b1);
         if (cyc == pulse_at + 1 && hold == 0) set_start(sel, 1'b0);
         if (cyc == abort_at) begin
            rst = 1'b1;
            set_start(sel, 1'b0);
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         if (sel == 0) begin we = a_out_we; ie = a_in_en; dn = a_done; oa = a_out_addr; od = a_out_data; end
         else          begin we = b_out_we; ie = b_in_en; dn = b_done; oa = b_out_addr; od = b_out_data; end
         if (ie) n_inen++;
         if (we) begin
            cap[oa[7:0]]  = int'($signed(od));
            capv[oa[7:0]] = 1'b1;
            n_wr++;
            if (last_wr >= 0 && cyc - last_wr != period) gap_bad++;
            last_wr = cyc;
         end
         if (dn) begin
            done_cyc = cyc;
            set_start(sel, 1'b0);
            break;
         end
      end
      if (done_cyc == 0) timed_out = 1'b1;
      @(negedge clk);
      post_busy = (sel == 0) ? a_busy : b_busy;
      post_done = (sel == 0) ? a_done : b_done;
   endtask

   task automatic fill_a(input int xin, input int wt, input int bias);
      for (int i = 0; i < 256; i++) begin a_in_mem[i] = xin; a_w_mem[i] = wt; a_b_mem[i] = bias; end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({a_busy, a_done, a_out_we, a_in_en, a_w_en, a_b_en} !== 6'b0) begin
         n_bad++; $display("FAIL reset_ctrl_a: got %b want 000000", {a_busy, a_done, a_out_we, a_in_en, a_w_en, a_b_en});
      end
      n_cmp++;
      if ({b_busy, b_done, b_out_we, b_in_en, b_w_en, b_b_en} !== 6'b0) begin
         n_bad++; $display("FAIL reset_ctrl_b: got %b want 000000", {b_busy, b_done, b_out_we, b_in_en, b_w_en, b_b_en});
      end
      n_cmp++;
      if ({a_in_addr, a_w_addr, a_b_addr, a_out_addr, a_out_data} !== 72'h0) begin
         n_bad++; $display("FAIL reset_data_a: got %h want 0", {a_in_addr, a_w_addr, a_b_addr, a_out_addr, a_out_data});
      end
      rst = 1'b0;
   endtask

   task automatic test_basic_padding;
      int exp9[9] = '{4, 6, 4, 6, 9, 6, 4, 6, 4};
      int inb;
      fill_a(1, 1, 0);
      run_layer(0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (timed_out || n_wr != 9) begin n_bad++; $display("FAIL basic_writes: got %0d want 9 (timeout=%0d)", n_wr, timed_out); end
      for (int i = 0; i < 9; i++) begin
         n_cmp++;
         if (!capv[i] || cap[i] != exp9[i] || cap[i] != ref_pix(0, 0, i/3, i%3, 0, 0)) begin
            n_bad++; $display("FAIL basic_pix%0d: got %0d want %0d", i, cap[i], exp9[i]);
         end
      end
      // Timing of the same run.
      n_cmp++;
      if (done_cyc != 1*3*3*(9+3)+1) begin n_bad++; $display("FAIL timing_done: got %0d want 109", done_cyc); end
      n_cmp++;
      if (gap_bad != 0) begin n_bad++; $display("FAIL timing_gap: got %0d bad gaps want 0", gap_bad); end
      inb = 0;
      for (int orow = 0; orow < 3; orow++)
         for (int ocol = 0; ocol < 3; ocol++)
            for (int kr = 0; kr < 3; kr++)
               for (int kc = 0; kc < 3; kc++)
                  if (orow+kr-1 >= 0 && orow+kr-1 < 3 && ocol+kc-1 >= 0 && ocol+kc-1 < 3) inb++;
      n_cmp++;
      if (n_inen != inb) begin n_bad++; $display("FAIL timing_in_en: got %0d want %0d", n_inen, inb); end
      n_cmp++;
      if (post_busy !== 1'b0 || post_done !== 1'b0) begin
         n_bad++; $display("FAIL after_done: got busy=%b done=%b want 0 0", post_busy, post_done);
      end
   endtask

   task automatic test_saturation;
      int w_tab[3] = '{127, -127, -127};
      int r_tab[3] = '{0, 0, 1};
      int e_tab[3] = '{127, -128, 0};
      for (int t = 0; t < 3; t++) begin
         fill_a(127, w_tab[t], 0);
         run_layer(0, 0, r_tab[t], 0, 0, 0);
         n_cmp++;
         if (!capv[4] || cap[4] != e_tab[t] || cap[4] != ref_pix(0, 0, 1, 1, 0, r_tab[t])) begin
            n_bad++; $display("FAIL sat%0d_centre: got %0d want %0d", t, cap[4], e_tab[t]);
         end
      end
   endtask

   task automatic test_rounding;
      int bias_tab[2] = '{0, -12};
      int e_tab[2] = '{2, -1};
      for (int t = 0; t < 2; t++) begin
         fill_a(3, 0, bias_tab[t]);
         a_w_mem[4] = 2;
         run_layer(0, 2, 0, 0, 0, 0);
         for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if (!capv[i] || cap[i] != e_tab[t]) begin
               n_bad++; $display("FAIL round%0d_pix%0d: got %0d want %0d", t, i, cap[i], e_tab[t]);
            end
         end
      end
   endtask

   task automatic test_multichannel;
      for (int i = 0; i < 256; i++) begin b_in_mem[i] = i/16 + 1; b_w_mem[i] = 1; b_b_mem[i] = i*10; end
      run_layer(1, 0, 0, 0, 0, 0);
      n_cmp++;
      if (timed_out || n_wr != 8) begin n_bad++; $display("FAIL mc_writes: got %0d want 8", n_wr); end
      n_cmp++;
      if (cap[0] != 24) begin n_bad++; $display("FAIL mc_out0: got %0d want 24", cap[0]); end
      n_cmp++;
      if (cap[4] != 34) begin n_bad++; $display("FAIL mc_out4: got %0d want 34", cap[4]); end
      n_cmp++;
      if (done_cyc != 2*2*2*(27+3)+1) begin n_bad++; $display("FAIL mc_done: got %0d want 241", done_cyc); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (!capv[i] || cap[i] != ref_pix(1, i/4, (i%4)/2, i%2, 0, 0)) begin
            n_bad++; $display("FAIL mc_pix%0d: got %0d want %0d", i, cap[i], ref_pix(1, i/4, (i%4)/2, i%2, 0, 0));
         end
      end
   endtask

   task automatic test_random;
      int shamt, relu;
      for (int it = 0; it < 4; it++) begin
         for (int i = 0; i < 256; i++) begin
            b_in_mem[i] = int'($urandom_range(255)) - 128;
            b_w_mem[i]  = int'($urandom_range(255)) - 128;
            b_b_mem[i]  = int'($urandom_range(20000)) - 10000;
         end
         shamt = int'($urandom_range(12));
         relu  = int'($urandom_range(1));
         run_layer(1, shamt, relu, 0, 0, 0);
         for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (!capv[i] || cap[i] != ref_pix(1, i/4, (i%4)/2, i%2, shamt, relu)) begin
               n_bad++; $display("FAIL rand%0d_pix%0d: got %0d want %0d (shift=%0d relu=%0d)",
                                 it, i, cap[i], ref_pix(1, i/4, (i%4)/2, i%2, shamt, relu), shamt, relu);
            end
         end
      end
   endtask

   task automatic test_start_while_busy;
      fill_a(1, 1, 0);
      run_layer(0, 0, 0, 0, 20, 0);
      n_cmp++;
      if (n_wr != 9 || done_cyc != 109) begin
         n_bad++; $display("FAIL busy_pulse: got writes=%0d done=%0d want 9 109", n_wr, done_cyc);
      end
      run_layer(0, 0, 0, 1, 0, 0);
      n_cmp++;
      if (n_wr != 9 || done_cyc != 109) begin
         n_bad++; $display("FAIL busy_hold: got writes=%0d done=%0d want 9 109", n_wr, done_cyc);
      end
      n_cmp++;
      if (post_busy !== 1'b0) begin n_bad++; $display("FAIL hold_retrigger: got busy=%b want 0", post_busy); end
   endtask

   task automatic test_reset_mid;
      int stray;
      fill_a(2, 1, 0);
      run_layer(0, 0, 0, 0, 0, 40);
      n_cmp++;
      if (a_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", a_busy); end
      stray = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (a_out_we !== 1'b0 || a_busy !== 1'b0) stray++;
      end
      n_cmp++;
      if (stray != 0) begin n_bad++; $display("FAIL abort_quiet: got %0d active cycles want 0", stray); end
      run_layer(0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (n_wr != 9 || done_cyc != 109) begin
         n_bad++; $display("FAIL rerun_timing: got writes=%0d done=%0d want 9 109", n_wr, done_cyc);
      end
      for (int i = 0; i < 9; i++) begin
         n_cmp++;
         if (!capv[i] || cap[i] != ref_pix(0, 0, i/3, i%3, 0, 0)) begin
            n_bad++; $display("FAIL rerun_pix%0d: got %0d want %0d", i, cap[i], ref_pix(0, 0, i/3, i%3, 0, 0));
         end
      end
   endtask

   initial begin
      test_reset;
      test_basic_padding;
      test_saturation;
      test_rounding;
      test_multichannel;
      test_random;
      test_start_while_busy;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
